imm_gen_stage: RTL and testbench

//  Registered, flow-controlled immediate generator for the decode stage of the async pipeline.

---
 rtl/imm_pkg.sv | 15 +
 rtl/imm_decode.sv | 43 ++++
 rtl/imm_gen_stage.sv | 92 +++++++++
 tb/tb_imm_gen_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4,
        IMM_Z = 3'd5
    } imm_src_e;

    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and extension from a 32-bit instruction word.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] w_imm32;
    logic        w_s;

    assign w_s = in_instr[31];

    always_comb begin
        w_imm32 = '0;
        illegal = 1'b0;
        case (imm_src_e'(in_imm_src))
            IMM_I: begin
                // CSR immediate forms reuse the I slot but carry a 5-bit uimm in rs1
                if (in_instr[6:0] == OPC_SYSTEM)
                    w_imm32 = {27'b0, in_instr[19:15]};
                else
                    w_imm32 = {{20{w_s}}, in_instr[31:20]};
            end
            IMM_S: w_imm32 = {{20{w_s}}, in_instr[31:25], in_instr[11:7]};
            IMM_B: w_imm32 = {{19{w_s}}, in_instr[31], in_instr[7], in_instr[30:25],
                              in_instr[11:8], 1'b0};
            IMM_J: w_imm32 = {{11{w_s}}, in_instr[31], in_instr[19:12], in_instr[20],
                              in_instr[30:21], 1'b0};
            IMM_U: w_imm32 = {in_instr[31:12], 12'b0};
            IMM_Z: w_imm32 = {27'b0, in_instr[19:15]};
            default: illegal = 1'b1;
        endcase
    end

    // Every format's bit 31 is its sign (Z forms have it clear), so one sign cast covers XLEN=64
    assign imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a one-entry skid buffer and flush.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit PASS_INSN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [31:0]     out_instr,
    output logic            out_illegal
);

    logic [XLEN-1:0] w_imm;
    logic            w_ill;
    logic [31:0]     w_instr;
    logic            w_accept;
    logic            w_emit;

    logic            r_vld;
    logic [XLEN-1:0] r_imm;
    logic [31:0]     r_instr;
    logic            r_ill;
    logic            r_skid_vld;
    logic [XLEN-1:0] r_skid_imm;
    logic [31:0]     r_skid_instr;
    logic            r_skid_ill;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .in_instr   (in_instr),
        .in_imm_src (in_imm_src),
        .imm        (w_imm),
        .illegal    (w_ill)
    );

    assign w_instr  = PASS_INSN ? in_instr : 32'b0;
    assign w_accept = in_valid & in_ready;
    assign w_emit   = r_vld & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld        <= 1'b0;
            r_imm        <= '0;
            r_instr      <= '0;
            r_ill        <= 1'b0;
            r_skid_vld   <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_instr <= '0;
            r_skid_ill   <= 1'b0;
        end else if (flush) begin
            r_vld      <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
            // in_ready is low here, so no accept can coincide with the skid drain
            if (w_emit) begin
                r_imm      <= r_skid_imm;
                r_instr    <= r_skid_instr;
                r_ill      <= r_skid_ill;
                r_skid_vld <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_vld || w_emit) begin
                r_vld   <= 1'b1;
                r_imm   <= w_imm;
                r_instr <= w_instr;
                r_ill   <= w_ill;
            end else begin
                r_skid_vld   <= 1'b1;
                r_skid_imm   <= w_imm;
                r_skid_instr <= w_instr;
                r_skid_ill   <= w_ill;
            end
        end else if (w_emit) begin
            r_vld <= 1'b0;
        end
    end

    assign in_ready    = ~r_skid_vld;
    assign out_valid   = r_vld;
    assign out_imm     = r_imm;
    assign out_instr   = r_instr;
    assign out_illegal = r_ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances driven by the same stimulus.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [2:0]  in_imm_src = '0;

    logic        in_ready32, in_ready64, out_valid32, out_valid64, out_ill32, out_ill64;
    logic [31:0] out_imm32, out_instr32, out_instr64;
    logic [63:0] out_imm64;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .PASS_INSN(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_instr(out_instr32),
        .out_illegal(out_ill32));

    imm_gen_stage #(.XLEN(64), .PASS_INSN(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_instr(out_instr64),
        .out_illegal(out_ill64));

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic        ill;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        ill;
    } vec_t;

    ent_t        q[$];
    int          npass = 0;
    int          ntot  = 0;
    bit          p_stall = 0;
    logic [31:0] p_instr;
    logic [2:0]  p_src;

    // Immediate computed from the format rules with plain signed arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
        longint si, u;
        si = $signed(ins);
        u  = longint'({32'h0, ins});
        if (src == 3'd0 && (u & 127) == 115) src = 3'd5;
        case (src)
            3'd0: return si >>> 20;
            3'd1: return ((si >>> 25) * 32) + ((u >> 7) & 31);
            3'd2: return ((si >>> 31) * 4096) + (((u >> 7) & 1) * 2048)
                       + (((u >> 25) & 63) * 32) + (((u >> 8) & 15) * 2);
            3'd3: return ((si >>> 31) * 1048576) + (((u >> 12) & 255) * 4096)
                       + (((u >> 20) & 1) * 2048) + (((u >> 21) & 1023) * 2);
            3'd4: return (si >>> 12) * 4096;
            3'd5: return (u >> 15) & 31;
            default: return 64'd0;
        endcase
    endfunction

    function automatic ent_t mk(input logic [31:0] ins, input logic [2:0] src);
        ent_t e;
        e.instr = ins;
        e.imm   = ref_imm(ins, src);
        e.ill   = (src > 3'd5);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // One clock: predict transfers from model occupancy, advance the model, compare #1 after the edge.
    task automatic step();
        int cnt;
        bit acc, emt;
        cnt = q.size();
        acc = in_valid && (cnt < 2);
        emt = (cnt > 0) && out_ready;
        if (p_stall && in_valid) begin
            chk("hold_instr", in_instr, p_instr);
            chk("hold_src", in_imm_src, p_src);
        end
        p_stall = in_valid && !acc;
        p_instr = in_instr;
        p_src   = in_imm_src;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (emt) void'(q.pop_front());
            if (acc) q.push_back(mk(in_instr, in_imm_src));
        end
        #1;
        chk("out_valid32", out_valid32, q.size() > 0);
        chk("out_valid64", out_valid64, q.size() > 0);
        chk("in_ready32", in_ready32, q.size() < 2);
        chk("in_ready64", in_ready64, q.size() < 2);
        if (q.size() > 0) begin
            chk("imm32", out_imm32, q[0].imm[31:0]);
            chk("imm64", out_imm64, q[0].imm);
            chk("instr32", out_instr32, q[0].instr);
            chk("instr64", out_instr64, q[0].instr);
            chk("ill32", out_ill32, q[0].ill);
            chk("ill64", out_ill64, q[0].ill);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [2:0] src);
        in_valid   = v;
        in_instr   = ins;
        in_imm_src = src;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid32, 1'b0);
        chk("rst_in_ready", in_ready32, 1'b1);
        q.delete();
        p_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vt[10];
    bit   hold;

    initial begin
        vt[0] = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vt[1] = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vt[2] = '{32'h123452B7, 3'd4, 32'h12345000, 64'h0000000012345000, 1'b0};
        vt[3] = '{32'h800002B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vt[4] = '{32'h3002D073, 3'd0, 32'h00000005, 64'h0000000000000005, 1'b0};
        vt[5] = '{32'h3002D073, 3'd5, 32'h00000005, 64'h0000000000000005, 1'b0};
        vt[6] = '{32'hFFF00093, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
        vt[7] = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vt[8] = '{32'hFF9FF06F, 3'd3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
        vt[9] = '{32'h00500093, 3'd6, 32'h00000000, 64'h0000000000000000, 1'b1};

        #12;
        chk("reset_out_valid", out_valid32, 1'b0);
        chk("reset_in_ready", in_ready32, 1'b1);
        chk("reset_out_imm", out_imm64, 64'd0);
        chk("reset_out_instr", out_instr32, 32'd0);
        chk("reset_out_illegal", out_ill32, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vt[i].instr, vt[i].src);
            step();
            chk($sformatf("vec%0d_valid", i), out_valid32, 1'b1);
            chk($sformatf("vec%0d_imm32", i), out_imm32, vt[i].exp32);
            chk($sformatf("vec%0d_imm64", i), out_imm64, vt[i].exp64);
            chk($sformatf("vec%0d_ill", i), out_ill32, vt[i].ill);
        end
        drive(1'b0, '0, '0);
        step();

        // Back-pressure: A in main, B in skid, C held upstream, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'hAAA00093, 3'd0); step();
        drive(1'b1, 32'hBBB00093, 3'd0); step();
        drive(1'b1, 32'hCCC00093, 3'd0); step();
        chk("bp_in_ready", in_ready32, 1'b0);
        chk("bp_main_A", out_instr32, 32'hAAA00093);
        out_ready = 1'b1;
        step(); chk("drain_B", out_instr32, 32'hBBB00093);
        step(); chk("drain_C", out_instr32, 32'hCCC00093);
        drive(1'b0, '0, '0);
        step(); chk("drain_empty", out_valid32, 1'b0);

        // Flush with both registers full and a pending input
        out_ready = 1'b0;
        drive(1'b1, 32'h11100093, 3'd0); step();
        drive(1'b1, 32'h22200093, 3'd0); step();
        drive(1'b1, 32'h33300093, 3'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_out_valid", out_valid32, 1'b0);
        chk("flush_in_ready", in_ready32, 1'b1);
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        step(); chk("flush_nothing", out_valid32, 1'b0);

        // Async reset mid-stream, then 1-cycle latency after release
        out_ready = 1'b0;
        drive(1'b1, 32'h44400093, 3'd0); step();
        drive(1'b1, 32'h55500093, 3'd0); step();
        async_reset();
        drive(1'b1, 32'h66600093, 3'd0); step();
        chk("post_rst_valid", out_valid32, 1'b1);
        chk("post_rst_instr", out_instr32, 32'h66600093);
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        step();

        hold = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_instr = $urandom;
                if ($urandom_range(0, 3) == 0) in_instr[6:0] = 7'h73;
                in_imm_src = 3'($urandom_range(0, 7));
            end
            out_ready = (i < 5000) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 63) == 0);
            hold = in_valid && (q.size() >= 2);
            step();
            flush = 1'b0;
            if (i == 5000) async_reset();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
